// File: rtl/lo_sweep_sequencer.sv
// lo_sweep_sequencer: non-overlapping LO pair generator with stepped divider sweep.
// Define SWEEP_LOOP_EN to restart the sweep from div_start at completion until aborted.
module lo_sweep_sequencer #(
    parameter int DIV_W    = 8,
    parameter int DWELL_W  = 12,
    parameter int DEAD_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DIV_W-1:0]   div_start,
    input  logic [DIV_W-1:0]   div_stop,
    input  logic [DWELL_W-1:0] dwell,
    output logic               lo_p,
    output logic               lo_n,
    output logic               busy,
    output logic               done,
    output logic               step_strobe,
    output logic [DIV_W-1:0]   cur_div
);
    localparam int DCW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam int CW  = (DIV_W >= DCW) ? DIV_W : DCW;
    localparam logic          DEAD_EN   = 1'(DEAD_CYC > 0);
    localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PH_P  = 3'd1;
    localparam logic [2:0] S_DEAD1 = 3'd2;
    localparam logic [2:0] S_PH_N  = 3'd3;
    localparam logic [2:0] S_DEAD2 = 3'd4;

    logic [2:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [DWELL_W-1:0] r_dwell_max;
    logic [DIV_W-1:0]   r_div_stop;
    logic [DIV_W-1:0]   r_cur_div;
    logic               r_up;
    logic               r_lo_p;
    logic               r_lo_n;
    logic               r_busy;
    logic               r_done;
    logic               r_step;
`ifdef SWEEP_LOOP_EN
    logic [DIV_W-1:0]   r_div_first;
`endif

    logic [2:0] w_nxt;
    logic [2:0] w_fin_state;
    logic       w_accept;
    logic       w_last_ph;
    logic       w_last_dead;
    logic       w_per_end;
    logic       w_dwell_end;
    logic       w_fin;
    logic       w_step;

`ifdef SWEEP_LOOP_EN
    assign w_fin_state = S_PH_P;
`else
    assign w_fin_state = S_IDLE;
`endif

    assign w_accept    = (r_state == S_IDLE) && start && !abort;
    assign w_last_ph   = r_cnt == CW'(r_cur_div);
    assign w_last_dead = r_cnt == DEAD_LAST;
    assign w_per_end   = DEAD_EN ? (r_state == S_DEAD2 && w_last_dead)
                                 : (r_state == S_PH_N && w_last_ph);
    assign w_dwell_end = w_per_end && (r_dwell_cnt == r_dwell_max - DWELL_W'(1));
    assign w_fin       = w_dwell_end && (r_cur_div == r_div_stop);
    assign w_step      = w_dwell_end && (r_cur_div != r_div_stop);

    // Abort overrides every transition, including acceptance and completion
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  w_nxt = w_accept ? S_PH_P : S_IDLE;
            S_PH_P:  if (w_last_ph) w_nxt = DEAD_EN ? S_DEAD1 : S_PH_N;
            S_DEAD1: if (w_last_dead) w_nxt = S_PH_N;
            S_PH_N:  if (w_last_ph) w_nxt = DEAD_EN ? S_DEAD2 : (w_fin ? w_fin_state : S_PH_P);
            S_DEAD2: if (w_last_dead) w_nxt = w_fin ? w_fin_state : S_PH_P;
            default: w_nxt = S_IDLE;
        endcase
        if (abort) w_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dwell_cnt <= '0;
            r_dwell_max <= '0;
            r_div_stop  <= '0;
            r_cur_div   <= '0;
            r_up        <= 1'b0;
            r_lo_p      <= 1'b0;
            r_lo_n      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_step      <= 1'b0;
`ifdef SWEEP_LOOP_EN
            r_div_first <= '0;
`endif
        end else begin
            r_state <= w_nxt;
            r_cnt   <= (w_nxt != r_state || w_nxt == S_IDLE) ? '0 : r_cnt + CW'(1);
            r_lo_p  <= w_nxt == S_PH_P;
            r_lo_n  <= w_nxt == S_PH_N;
            r_busy  <= w_nxt != S_IDLE;
            r_done  <= w_fin && !abort;
            r_step  <= w_step && !abort;
            if (w_accept) begin
                r_cur_div   <= div_start;
                r_div_stop  <= div_stop;
                r_up        <= div_start < div_stop;
                r_dwell_max <= (dwell == '0) ? DWELL_W'(1) : dwell;
                r_dwell_cnt <= '0;
`ifdef SWEEP_LOOP_EN
                r_div_first <= div_start;
`endif
            end else if (w_per_end && !abort) begin
                r_dwell_cnt <= w_dwell_end ? '0 : r_dwell_cnt + DWELL_W'(1);
                if (w_step)
                    r_cur_div <= r_up ? r_cur_div + DIV_W'(1) : r_cur_div - DIV_W'(1);
`ifdef SWEEP_LOOP_EN
                else if (w_fin)
                    r_cur_div <= r_div_first;
`endif
            end
        end
    end

    assign lo_p        = r_lo_p;
    assign lo_n        = r_lo_n;
    assign busy        = r_busy;
    assign done        = r_done;
    assign step_strobe = r_step;
    assign cur_div     = r_cur_div;
endmodule

// File: tb/tb_lo_sweep_sequencer.sv
// tb_lo_sweep_sequencer: directed sweeps checked cycle-by-cycle against a waveform model.
module tb_lo_sweep_sequencer;
    localparam int DEAD = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  div_start = '0;
    logic [7:0]  div_stop = '0;
    logic [11:0] dwell = '0;
    logic        lo_p, lo_n, busy, done, step_strobe;
    logic [7:0]  cur_div;

    lo_sweep_sequencer #(.DIV_W(8), .DWELL_W(12), .DEAD_CYC(DEAD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .div_start(div_start), .div_stop(div_stop), .dwell(dwell),
        .lo_p(lo_p), .lo_n(lo_n), .busy(busy), .done(done),
        .step_strobe(step_strobe), .cur_div(cur_div)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       p;
        logic       n;
        logic       b;
        logic       d;
        logic       s;
        logic [7:0] c;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_cur = '0;
    logic       cur_busy = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         obs_busy = 0;
    int         obs_step = 0;
    int         obs_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // Expected waveform: each LO period is lo_p for d+1, gap, lo_n for d+1, gap
    task automatic push_sweep(input logic [7:0] ds, input logic [7:0] dp, input logic [11:0] dw);
        int   d = ds;
        int   dm = (dw == 0) ? 1 : dw;
        bit   first = 1'b1;
        bit   last = 1'b0;
        exp_t e;
        while (!last) begin
            for (int r = 0; r < dm; r++)
                for (int k = 0; k < 2 * (d + 1 + DEAD); k++) begin
                    e.p = (k <= d);
                    e.n = (k >= d + 1 + DEAD) && (k - (d + 1 + DEAD) <= d);
                    e.b = 1'b1;
                    e.d = 1'b0;
                    e.s = !first && r == 0 && k == 0;
                    e.c = 8'(d);
                    q.push_back(e);
                end
            if (d == int'(dp)) last = 1'b1;
            else d = (ds < dp) ? d + 1 : d - 1;
            first = 1'b0;
        end
        e = '0;
        e.d = 1'b1;
        e.c = 8'(d);
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (!rst_n) q.delete();
        else if (!cur_busy) begin
            if (start && !abort) push_sweep(div_start, div_stop, dwell);
        end else if (abort) q.delete();
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) e = '0;
        else if (q.size() > 0) e = q.pop_front();
        else begin
            e = '0;
            e.c = m_cur;
        end
        chk("cycle", 32'({lo_p, lo_n, busy, done, step_strobe, cur_div}), 32'(e));
        m_cur = e.c;
        cur_busy = e.b;
        assert (!(lo_p && lo_n)) else $error("lo_p and lo_n high together");
        obs_busy += int'(busy);
        obs_step += int'(step_strobe);
        obs_done += int'(done);
    end

    task automatic do_start(input logic [7:0] ds, input logic [7:0] dp, input logic [11:0] dw);
        @(negedge clk);
        #1;
        div_start = ds;
        div_stop = dp;
        dwell = dw;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        div_start = 8'hA5;
        div_stop = 8'h5A;
        dwell = 12'h7;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() > 0 || cur_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic sweep(input string nm, input logic [7:0] ds, input logic [7:0] dp,
                         input logic [11:0] dw, input int len, input int steps);
        int b0 = obs_busy, s0 = obs_step, d0 = obs_done;
        do_start(ds, dp, dw);
        chk({nm, "_model_len"}, q.size(), len + 1);
        drain();
        chk({nm, "_busy_cycles"}, obs_busy - b0, len);
        chk({nm, "_steps"}, obs_step - s0, steps);
        chk({nm, "_dones"}, obs_done - d0, 1);
    endtask

    logic [4:0] ss[9] = '{5'b10100, 5'b10100, 5'b10100, 5'b00100,
                          5'b01100, 5'b01100, 5'b01100, 5'b00100, 5'b00010};

    initial begin
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_start(8'd2, 8'd2, 12'd1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("single_step", {lo_p, lo_n, busy, done, step_strobe}, ss[i]);
        end
        drain();

        sweep("up", 8'd1, 8'd3, 12'd2, 48, 2);
        sweep("down", 8'd3, 8'd1, 12'd0, 24, 2);

        do_start(8'd1, 8'd3, 12'd2);
        repeat (18) @(negedge clk);
        chk("pre_abort", {lo_n, busy, cur_div}, {1'b1, 1'b1, 8'd2});
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort", {lo_p, lo_n, busy, done, step_strobe, cur_div}, {5'b0, 8'd2});
        repeat (3) @(negedge clk);
        do_start(8'd1, 8'd3, 12'd2);
        @(negedge clk);
        chk("restart", {lo_p, busy, cur_div}, {1'b1, 1'b1, 8'd1});
        drain();

        @(negedge clk);
        #1;
        div_start = 8'd1;
        div_stop = 8'd3;
        dwell = 12'd2;
        start = 1'b1;
        repeat (49) @(negedge clk);
        chk("held_done", {busy, done}, 2'b01);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("held_restart", {busy, done, cur_div}, {2'b10, 8'd1});
        drain();

        @(negedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_abort_idle", busy, 1'b0);

        do_start(8'd2, 8'd2, 12'd1);
        repeat (8) @(negedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_final", {busy, done, cur_div}, {2'b00, 8'd2});
        repeat (2) @(negedge clk);

        do_start(8'd1, 8'd3, 12'd2);
        repeat (2) @(negedge clk);
        chk("pre_reset", {lo_p, busy}, 2'b11);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {lo_p, lo_n, busy, done, step_strobe, cur_div}, 13'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
